// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg
//   Shared 7-segment definitions for both ends of the display bus: the
//   digit-to-cathode encoder and the seg_scan_decoder readback monitor.
//   Cathodes are active-low, bit6=g ... bit0=a.
//
//   Contents:
//     SEG_W          cathode bus width
//     SEG_0..SEG_F   cathode pattern per hex digit
//     SEG_BLANK      all segments off
//     BCD_INVALID    digit code reported for an unrecognised pattern
//     seg_dec_t      decode result {invalid, digit}
//     digit_to_seg   encoder table (full hex)
//     seg_to_digit   decoder table
//
//   Build option: SEG_SCAN_DECODER_HEX_EN
//     defined   -> seg_to_digit also accepts the A..F patterns
//     undefined -> A..F patterns are treated as invalid
package seg_scan_decoder_pkg;

  localparam int SEG_W = 7;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic       invalid;
    logic [3:0] digit;
  } seg_dec_t;

  // Encoder side: every 4-bit code has a glyph.
  function automatic logic [SEG_W-1:0] digit_to_seg(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

  // Decoder side: anything not in the table, including blank, is invalid.
  function automatic seg_dec_t seg_to_digit(input logic [SEG_W-1:0] seg);
    seg_dec_t r;
    r.invalid = 1'b0;
    r.digit   = BCD_INVALID;
    case (seg)
      SEG_0: r.digit = 4'h0;
      SEG_1: r.digit = 4'h1;
      SEG_2: r.digit = 4'h2;
      SEG_3: r.digit = 4'h3;
      SEG_4: r.digit = 4'h4;
      SEG_5: r.digit = 4'h5;
      SEG_6: r.digit = 4'h6;
      SEG_7: r.digit = 4'h7;
      SEG_8: r.digit = 4'h8;
      SEG_9: r.digit = 4'h9;
`ifdef SEG_SCAN_DECODER_HEX_EN
      SEG_A: r.digit = 4'hA;
      SEG_B: r.digit = 4'hB;
      SEG_C: r.digit = 4'hC;
      SEG_D: r.digit = 4'hD;
      SEG_E: r.digit = 4'hE;
      SEG_F: r.digit = 4'hF;
`endif
      default: begin
        r.digit   = BCD_INVALID;
        r.invalid = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_decode.sv
// seg_pattern_decode
//   Combinational cathode-pattern to digit decoder built on the shared
//   package table.
//
//   Ports:
//     seg      in  SEG_W  cathode pattern, active-low, bit6=g ... bit0=a
//     digit    out 4      decoded digit, BCD_INVALID when unrecognised
//     invalid  out 1      pattern not in the table
//
//   Build option: SEG_SCAN_DECODER_HEX_EN (adds A..F, via the package).
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       digit,
  output logic             invalid
);

  seg_dec_t dec;

  always_comb begin
    dec     = seg_to_digit(seg);
    digit   = dec.digit;
    invalid = dec.invalid;
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Readback monitor for a multiplexed 7-segment display. Watches the
//   anode/cathode bus, captures each digit once it has been stable for
//   STABLE_CYCLES samples, and publishes a 4-bit-per-digit word once every
//   digit slot has been captured at least once.
//
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     anode_in     in   NUM_DIGITS anodes, active-low, bit i = digit i
//     cathode_in   in   7 segments, active-low, bit6=g ... bit0=a
//     digits_out   out  decoded digits, digit i at [4i+3:4i]
//     frame_valid  out  one-cycle pulse when digits_out updates
//     frame_err    out  frame contained an undecodable digit (held until
//                       the next frame_valid)
//     timeout      out  one-cycle pulse when no frame completed within
//                       TIMEOUT_CYCLES
//
//   Build option: SEG_SCAN_DECODER_HEX_EN (decode A..F as valid digits).
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   anode_in,
  input  logic [SEG_W-1:0]        cathode_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    timeout
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]      STAB_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      STAB_PRE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  // Registered bus sample and the sample before it.
  logic [NUM_DIGITS-1:0]   an_r, an_p;
  logic [SEG_W-1:0]        cat_r, cat_p;

  logic [CNT_W-1:0]        stab_cnt, stab_cnt_nxt;
  logic [TO_W-1:0]         to_cnt;
  logic [NUM_DIGITS-1:0]   seen, seen_nxt;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic                    err_flag, err_nxt;

  logic [NUM_DIGITS-1:0]   an_low;
  logic                    one_low;
  logic                    same_pair;
  logic                    capture;
  logic                    frame_done;
  logic                    timeout_hit;
  logic [3:0]              dec_digit;
  logic                    dec_invalid;

  seg_pattern_decode u_decode (
    .seg     (cat_r),
    .digit   (dec_digit),
    .invalid (dec_invalid)
  );

  // Exactly one anode low: non-zero and a power of two in active-high form.
  always_comb begin
    an_low    = ~an_r;
    one_low   = (an_low != '0) && ((an_low & (an_low - AN_ONE)) == '0);
    same_pair = (an_r == an_p) && (cat_r == cat_p);
  end

  // Stability counter. Capture fires only on the step into STABLE_CYCLES,
  // so a long dwell on one digit yields a single capture.
  always_comb begin
    stab_cnt_nxt = stab_cnt;
    capture      = 1'b0;
    if (!one_low) begin
      stab_cnt_nxt = '0;
    end else if (same_pair) begin
      if (stab_cnt != STAB_MAX) begin
        stab_cnt_nxt = stab_cnt + CNT_W'(1);
      end
      capture = (stab_cnt == STAB_PRE);
    end else begin
      stab_cnt_nxt = CNT_W'(1);
    end
  end

  always_comb begin
    frame_done  = &seen;
    // A completing frame restarts the timeout counter, so it never also
    // times out in the same cycle.
    timeout_hit = !frame_done && (to_cnt == TO_LAST);
  end

  // Frame bookkeeping. Clearing is applied first so that a capture landing
  // in the completion/timeout cycle is kept for the next frame.
  always_comb begin
    seen_nxt   = seen;
    err_nxt    = err_flag;
    shadow_nxt = shadow;
    if (frame_done || timeout_hit) begin
      seen_nxt = '0;
      err_nxt  = 1'b0;
    end
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_low[i]) begin
          seen_nxt[i]             = 1'b1;
          shadow_nxt[4*i +: 4]    = dec_digit;
        end
      end
      if (dec_invalid) begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Input pipeline idles as a blanked display.
      an_r        <= '1;
      an_p        <= '1;
      cat_r       <= '1;
      cat_p       <= '1;
      stab_cnt    <= '0;
      to_cnt      <= '0;
      seen        <= '0;
      shadow      <= '0;
      err_flag    <= 1'b0;
      digits_out  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      an_r        <= anode_in;
      cat_r       <= cathode_in;
      an_p        <= an_r;
      cat_p       <= cat_r;
      stab_cnt    <= stab_cnt_nxt;
      seen        <= seen_nxt;
      shadow      <= shadow_nxt;
      err_flag    <= err_nxt;
      frame_valid <= frame_done;
      timeout     <= timeout_hit;
      if (frame_done) begin
        digits_out <= shadow;
        frame_err  <= err_flag;
      end
      if (frame_done || timeout_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int ND  = 4;
  localparam int STB = 4;
  localparam int TO  = 400;

  // Bench-side cathode table, independent of the design package.
  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_A     = 7'b0001000;
  localparam logic [6:0] P_B     = 7'b0000011;
  localparam logic [6:0] P_C     = 7'b1000110;
  localparam logic [6:0] P_D     = 7'b0100001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [ND-1:0] anode_in;
  logic [6:0]    cathode_in;
  logic [15:0]   digits_out;
  logic          frame_valid;
  logic          frame_err;
  logic          timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  int          fv_cnt = 0;
  int          to_cnt = 0;
  logic [15:0] last_digits = '0;
  logic        last_err = 1'b0;

  seg_scan_decoder #(
    .NUM_DIGITS     (ND),
    .STABLE_CYCLES  (STB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .anode_in    (anode_in),
    .cathode_in  (cathode_in),
    .digits_out  (digits_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .timeout     (timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observe output pulses on the falling edge.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      last_digits = digits_out;
      last_err    = frame_err;
    end
    if (timeout === 1'b1) to_cnt++;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [6:0] bseg(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b1000000;
      1: s = 7'b1111001;
      2: s = 7'b0100100;
      3: s = 7'b0110000;
      4: s = 7'b0011001;
      5: s = 7'b0010010;
      6: s = 7'b0000010;
      7: s = 7'b1111000;
      8: s = 7'b0000000;
      default: s = 7'b0010000;
    endcase
    return s;
  endfunction

  task automatic show(input int idx, input logic [6:0] seg, input int dwell);
    logic [ND-1:0] a;
    a          = 4'b0001 << idx;
    anode_in   = ~a;
    cathode_in = seg;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic blank(input int n);
    anode_in   = '1;
    cathode_in = P_BLANK;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_frame(input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0,
                            input int dwell);
    show(3, s3, dwell);
    show(2, s2, dwell);
    show(1, s1, dwell);
    show(0, s0, dwell);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n      = 1'b0;
    anode_in   = '1;
    cathode_in = P_BLANK;
    repeat (3) @(negedge clk);
    n_cmp++; if (digits_out !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", digits_out); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst_n = 1'b1;
    blank(4);
  endtask

  task automatic test_frames;
    int base;
    base = fv_cnt;
    repeat (3) scan_frame(bseg(1), bseg(2), bseg(3), bseg(4), 8);
    blank(4);
    n_cmp++; if (fv_cnt - base !== 3) begin n_fail++; $display("FAIL frames_count: got %0d want 3", fv_cnt - base); end
    n_cmp++; if (last_digits !== 16'h1234) begin n_fail++; $display("FAIL frames_digits: got %h want 1234", last_digits); end
    n_cmp++; if (last_err !== 1'b0) begin n_fail++; $display("FAIL frames_err: got %b want 0", last_err); end
  endtask

  task automatic test_latency;
    int lat;
    lat = 0;
    show(3, bseg(5), 8);
    show(2, bseg(6), 8);
    show(1, bseg(7), 8);
    anode_in   = 4'b1110;
    cathode_in = bseg(8);
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (frame_valid === 1'b1) break;
    end
    n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL latency: got %0d cycles want 6", lat); end
    n_cmp++; if (digits_out !== 16'h5678) begin n_fail++; $display("FAIL latency_digits: got %h want 5678", digits_out); end
    @(negedge clk);
    n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL fv_pulse_width: got %b want 0", frame_valid); end
    blank(4);
  endtask

  task automatic test_timeout;
    int base_fv, base_to, waited, k, idx;
    base_fv = fv_cnt;
    base_to = to_cnt;
    waited  = 0;
    k       = 0;
    // Dwell of 3 is one short of the capture threshold.
    while (to_cnt == base_to && waited < TO + 100) begin
      idx = 3 - (k % 4);
      show(idx, bseg(idx + 1), 3);
      waited += 3;
      k++;
    end
    blank(2);
    n_cmp++; if (to_cnt - base_to !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d want 1", to_cnt - base_to); end
    n_cmp++; if (fv_cnt !== base_fv) begin n_fail++; $display("FAIL timeout_no_frame: got %0d frames want 0", fv_cnt - base_fv); end
    n_cmp++; if (digits_out !== 16'h5678) begin n_fail++; $display("FAIL timeout_hold: got %h want 5678", digits_out); end
  endtask

  task automatic test_error;
    int base;
    base = fv_cnt;
    scan_frame(bseg(5), P_BLANK, bseg(7), bseg(8), 8);
    blank(6);
    n_cmp++; if (fv_cnt - base !== 1) begin n_fail++; $display("FAIL err_count: got %0d want 1", fv_cnt - base); end
    n_cmp++; if (last_digits !== 16'h5F78) begin n_fail++; $display("FAIL err_digits: got %h want 5f78", last_digits); end
    n_cmp++; if (last_err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", last_err); end
    n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL err_hold: got %b want 1", frame_err); end
    scan_frame(bseg(1), bseg(2), bseg(3), bseg(4), 8);
    blank(4);
    n_cmp++; if (last_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", last_err); end
  endtask

  task automatic test_multi_low;
    int base;
    base = fv_cnt;
    // Preload slots 3 and 2, then hold digits 1 and 0 low together.
    show(3, bseg(1), 8);
    show(2, bseg(1), 8);
    anode_in   = 4'b1100;
    cathode_in = bseg(1);
    repeat (20) @(negedge clk);
    n_cmp++; if (fv_cnt !== base) begin n_fail++; $display("FAIL multi_low_capture: got %0d frames want 0", fv_cnt - base); end
    blank(2);
    scan_frame(bseg(9), bseg(8), bseg(7), bseg(6), 8);
    blank(4);
    n_cmp++; if (fv_cnt - base !== 1) begin n_fail++; $display("FAIL multi_low_count: got %0d want 1", fv_cnt - base); end
    n_cmp++; if (last_digits !== 16'h9876) begin n_fail++; $display("FAIL multi_low_digits: got %h want 9876", last_digits); end
  endtask

  task automatic test_reset_mid;
    int base;
    show(3, bseg(1), 8);
    show(2, bseg(2), 8);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (digits_out !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_digits: got %h want 0000", digits_out); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_err: got %b want 0", frame_err); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_fv: got %b want 0", frame_valid); end
    blank(2);
    rst_n = 1'b1;
    blank(2);
    base = fv_cnt;
    show(1, bseg(2), 8);
    show(0, bseg(1), 8);
    blank(4);
    n_cmp++; if (fv_cnt !== base) begin n_fail++; $display("FAIL mid_reset_partial: got %0d frames want 0", fv_cnt - base); end
    show(3, bseg(4), 8);
    show(2, bseg(3), 8);
    blank(4);
    n_cmp++; if (fv_cnt - base !== 1) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 1", fv_cnt - base); end
    n_cmp++; if (last_digits !== 16'h4321) begin n_fail++; $display("FAIL mid_reset_digits2: got %h want 4321", last_digits); end
  endtask

  task automatic test_hex;
    int base;
    logic [15:0] exp_d;
    logic        exp_e;
`ifdef SEG_SCAN_DECODER_HEX_EN
    exp_d = 16'hABCD;
    exp_e = 1'b0;
`else
    exp_d = 16'hFFFF;
    exp_e = 1'b1;
`endif
    base = fv_cnt;
    scan_frame(P_A, P_B, P_C, P_D, 8);
    blank(4);
    n_cmp++; if (fv_cnt - base !== 1) begin n_fail++; $display("FAIL hex_count: got %0d want 1", fv_cnt - base); end
    n_cmp++; if (last_digits !== exp_d) begin n_fail++; $display("FAIL hex_digits: got %h want %h", last_digits, exp_d); end
    n_cmp++; if (last_err !== exp_e) begin n_fail++; $display("FAIL hex_err: got %b want %b", last_err, exp_e); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n      = 1'b0;
    anode_in   = '1;
    cathode_in = P_BLANK;
    @(negedge clk);
    test_reset();
    test_frames();
    test_latency();
    test_timeout();
    test_error();
    test_multi_low();
    test_reset_mid();
    test_hex();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
